// File: rtl/ether_pkg.sv
// Shared Ethernet constants and receive-FSM state type for the GMII front end.
package ether_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_BODY,
    ST_DROP
  } rx_state_t;

endpackage

// File: rtl/ether_rx_frame_if.sv
// Payload byte stream leaving the receive front end, with frame strobes and verdict.
interface ether_rx_frame_if;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sof;
  logic       out_end;
  logic       out_good;

  modport master (output out_data, output out_valid, output out_sof,
                  output out_end, output out_good);
  modport slave  (input  out_data, input  out_valid, input  out_sof,
                  input  out_end, input  out_good);

endinterface

// File: rtl/ether_crc32_d8.sv
// Byte-wide IEEE 802.3 CRC-32 step (reflected, LSB first); shared with the TX path.
module ether_crc32_d8
  import ether_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/ether_rx_frame.sv
// GMII receive front end: preamble/SFD detection, FCS strip, CRC/length check,
// payload stream with sof/end strobes and saturating frame statistics.
module ether_rx_frame
  import ether_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             phy_rx_clk,
  input  logic             rst,
  input  logic             phy_rx_dv,
  input  logic             phy_rx_er,
  input  logic [7:0]       phy_rx_data,
  ether_rx_frame_if.master out_if,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_bad,
  output logic [CNT_W-1:0] cnt_drop
);

  // Byte count saturates one past MAX_LEN so giants never wrap back into range.
  localparam int                LEN_W   = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0]  LEN_MIN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]  LEN_FCS = LEN_W'(4);
  localparam logic [CNT_W-1:0]  CNT_TOP = '1;

  logic             dv_q;
  logic             er_q;
  logic [7:0]       data_q;
  rx_state_t        state;
  logic [3:0][7:0]  dly;
  logic [31:0]      crc;
  logic [31:0]      crc_nxt;
  logic [LEN_W-1:0] cnt;
  logic             er_seen;
  logic             frame_good;

  ether_crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (data_q),
    .crc_out (crc_nxt)
  );

  assign frame_good = (crc == CRC_RESIDUE) && !er_seen &&
                      (cnt >= LEN_MIN) && (cnt <= LEN_MAX);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_TOP) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge phy_rx_clk or negedge rst) begin
    if (!rst) begin
      dv_q             <= 1'b0;
      er_q             <= 1'b0;
      data_q           <= '0;
      state            <= ST_IDLE;
      dly              <= '0;
      crc              <= CRC_INIT;
      cnt              <= '0;
      er_seen          <= 1'b0;
      out_if.out_data  <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_sof   <= 1'b0;
      out_if.out_end   <= 1'b0;
      out_if.out_good  <= 1'b0;
      cnt_ok           <= '0;
      cnt_bad          <= '0;
      cnt_drop         <= '0;
    end else begin
      dv_q   <= phy_rx_dv;
      er_q   <= phy_rx_er;
      data_q <= phy_rx_data;

      out_if.out_valid <= 1'b0;
      out_if.out_sof   <= 1'b0;
      out_if.out_end   <= 1'b0;
      out_if.out_good  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (dv_q) begin
            if (data_q == PREAMBLE_BYTE) begin
              state <= ST_PRE;
            end else begin
              state    <= ST_DROP;
              cnt_drop <= sat_inc(cnt_drop);
            end
          end
        end

        ST_PRE: begin
          if (dv_q && data_q == PREAMBLE_BYTE) begin
            state <= ST_PRE;
          end else if (dv_q && data_q == SFD_BYTE) begin
            state   <= ST_BODY;
            crc     <= CRC_INIT;
            cnt     <= '0;
            er_seen <= 1'b0;
          end else begin
            state    <= ST_DROP;
            cnt_drop <= sat_inc(cnt_drop);
          end
        end

        ST_BODY: begin
          if (dv_q) begin
            crc     <= crc_nxt;
            dly     <= {dly[2:0], data_q};
            er_seen <= er_seen | er_q;
            if (cnt <= LEN_MAX) cnt <= cnt + 1'b1;
            // A byte leaves the delay line only when four newer bytes exist, so the FCS never does.
            if (cnt >= LEN_FCS && cnt < LEN_MAX) begin
              out_if.out_data  <= dly[3];
              out_if.out_valid <= 1'b1;
              out_if.out_sof   <= (cnt == LEN_FCS);
            end
          end else begin
            out_if.out_end  <= 1'b1;
            out_if.out_good <= frame_good;
            if (frame_good) cnt_ok  <= sat_inc(cnt_ok);
            else            cnt_bad <= sat_inc(cnt_bad);
            state <= ST_IDLE;
          end
        end

        ST_DROP: begin
          if (!dv_q) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ether_rx_frame.sv
// Self-checking bench for ether_rx_frame: vector table, hand-written corner
// sequences and randomized frames checked against a frame-level reference model.
module tb_ether_rx_frame;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int CNT_W   = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  typedef logic [7:0] bq_t[$];
  typedef bit         bitq_t[$];

  typedef struct {
    int         pre_n;
    logic [7:0] sfd;
    int         data_n;
    bit         add_fcs;
    int         flip_idx;
    int         er_idx;
    int         ifg;
    int         exp_beats;
    bit         exp_end;
    bit         exp_good;
    bit         exp_drop;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             dv = 1'b0;
  logic             er = 1'b0;
  logic [7:0]       data = '0;
  logic [CNT_W-1:0] cnt_ok, cnt_bad, cnt_drop;

  ether_rx_frame_if rx_if ();

  ether_rx_frame #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .phy_rx_clk  (clk),
    .rst         (rst),
    .phy_rx_dv   (dv),
    .phy_rx_er   (er),
    .phy_rx_data (data),
    .out_if      (rx_if),
    .cnt_ok      (cnt_ok),
    .cnt_bad     (cnt_bad),
    .cnt_drop    (cnt_drop)
  );

  always #4 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_body   = 0;
  int t_low    = 0;

  always @(posedge clk) cyc++;

  // Observed stream, captured away from the active edge.
  logic [7:0] obs_data[$];
  bit         obs_sof[$];
  bit         obs_good[$];
  int         obs_cyc[$];
  int         obs_end_cyc[$];

  always @(negedge clk) begin
    if (rx_if.out_valid) begin
      obs_data.push_back(rx_if.out_data);
      obs_sof.push_back(rx_if.out_sof);
      obs_cyc.push_back(cyc);
    end
    if (rx_if.out_end) begin
      obs_good.push_back(rx_if.out_good);
      obs_end_cyc.push_back(cyc);
    end
  end

  logic [7:0] exp_data[$];
  bit         exp_sof[$];
  bit         exp_good[$];
  int         exp_ok = 0, exp_bad = 0, exp_drop = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CNT_SAT) ? v : v + 1;
  endfunction

  function automatic logic [31:0] fcs_of(input bq_t b, input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) begin
      c ^= {24'h0, b[k]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input int pre_n, input logic [7:0] sfd, input int data_n,
                       input bit add_fcs, input int flip_idx, input int er_idx, input bit rnd,
                       output bq_t s, output bitq_t e, output int body0);
    bq_t         body;
    logic [31:0] f;
    s = {};
    e = {};
    for (int k = 0; k < data_n; k++) body.push_back(rnd ? 8'($urandom) : 8'(k));
    if (add_fcs) begin
      f = fcs_of(body, data_n);
      body.push_back(f[7:0]);
      body.push_back(f[15:8]);
      body.push_back(f[23:16]);
      body.push_back(f[31:24]);
    end
    if (flip_idx >= 0 && flip_idx < body.size()) body[flip_idx] ^= 8'h01;
    for (int k = 0; k < pre_n; k++) s.push_back(8'h55);
    s.push_back(sfd);
    body0 = s.size();
    foreach (body[k]) s.push_back(body[k]);
    foreach (s[k]) e.push_back(1'b0);
    if (er_idx >= 0 && body0 + er_idx < s.size()) e[body0 + er_idx] = 1'b1;
  endtask

  task automatic send(input bq_t s, input bitq_t e, input int body0, input int ifg);
    foreach (s[i]) begin
      @(negedge clk);
      dv = 1'b1; er = e[i]; data = s[i];
      if (i == body0) t_body = cyc + 1;
    end
    @(negedge clk);
    dv = 1'b0; er = 1'b0; data = '0;
    t_low = cyc + 1;
    repeat (ifg - 1) @(negedge clk);
  endtask

  // Frame-level model: parse preamble/SFD, then judge the body by its own FCS and length.
  task automatic model_frame(input bq_t s, input bitq_t e);
    int n = s.size();
    int i = 0;
    int len, nemit;
    bit er_any = 0, fcs_ok, good;
    bq_t body;
    if (n == 0) return;
    if (s[0] != 8'h55) begin exp_drop = sat(exp_drop); return; end
    while (i < n && s[i] == 8'h55) i++;
    if (i == n || s[i] != 8'hD5) begin exp_drop = sat(exp_drop); return; end
    for (int k = i + 1; k < n; k++) begin
      body.push_back(s[k]);
      er_any |= e[k];
    end
    len   = body.size();
    nemit = (len > 4) ? len - 4 : 0;
    if (nemit > MAX_LEN - 4) nemit = MAX_LEN - 4;
    for (int k = 0; k < nemit; k++) begin
      exp_data.push_back(body[k]);
      exp_sof.push_back(k == 0);
    end
    fcs_ok = (len >= 4) &&
             (fcs_of(body, len - 4) == {body[len-1], body[len-2], body[len-3], body[len-4]});
    good = fcs_ok && !er_any && len >= MIN_LEN && len <= MAX_LEN;
    exp_good.push_back(good);
    if (good) exp_ok = sat(exp_ok);
    else      exp_bad = sat(exp_bad);
  endtask

  task automatic clear_all();
    obs_data = {}; obs_sof = {}; obs_good = {}; obs_cyc = {}; obs_end_cyc = {};
    exp_data = {}; exp_sof = {}; exp_good = {};
  endtask

  task automatic flush(input string name);
    int mism = 0;
    repeat (3) @(negedge clk);
    #1;
    check({name, "/beats"}, obs_data.size(), exp_data.size());
    foreach (exp_data[k])
      if (k < obs_data.size() && (obs_data[k] != exp_data[k] || obs_sof[k] != exp_sof[k])) mism++;
    check({name, "/data_sof_mismatches"}, mism, 0);
    check({name, "/ends"}, obs_good.size(), exp_good.size());
    mism = 0;
    foreach (exp_good[k])
      if (k < obs_good.size() && obs_good[k] != exp_good[k]) mism++;
    check({name, "/good_mismatches"}, mism, 0);
    check({name, "/cnt_ok"},   int'(cnt_ok),   exp_ok);
    check({name, "/cnt_bad"},  int'(cnt_bad),  exp_bad);
    check({name, "/cnt_drop"}, int'(cnt_drop), exp_drop);
    clear_all();
  endtask

  vec_t  tbl[16];
  bq_t   s;
  bitq_t e;
  int    b0;

  initial begin
    //          pre  sfd    len fcs flip er  ifg beats end good drop
    tbl[0]  = '{7, 8'hD5,   60, 1, -1,   -1, 8,  60,   1,  1,   0};
    tbl[1]  = '{7, 8'hD5,   60, 1, 16,   -1, 8,  60,   1,  0,   0};
    tbl[2]  = '{7, 8'hD4,   20, 0, -1,   -1, 1,  0,    0,  0,   1};
    tbl[3]  = '{7, 8'hD5,   60, 1, -1,   -1, 8,  60,   1,  1,   0};
    tbl[4]  = '{7, 8'hD5,   36, 1, -1,   -1, 8,  36,   1,  0,   0};
    tbl[5]  = '{7, 8'hD5,   60, 1, -1,   30, 8,  60,   1,  0,   0};
    tbl[6]  = '{7, 8'hD5,   60, 1, -1,   -1, 1,  60,   1,  1,   0};
    tbl[7]  = '{7, 8'hD5,   60, 1, -1,   -1, 8,  60,   1,  1,   0};
    tbl[8]  = '{7, 8'hD5,   59, 1, -1,   -1, 8,  59,   1,  0,   0};
    tbl[9]  = '{7, 8'hD5, 1514, 1, -1,   -1, 8,  1514, 1,  1,   0};
    tbl[10] = '{7, 8'hD5, 1515, 1, -1,   -1, 8,  1514, 1,  0,   0};
    tbl[11] = '{7, 8'hD5,    3, 0, -1,   -1, 8,  0,    1,  0,   0};
    tbl[12] = '{1, 8'hD5,   60, 1, -1,   -1, 8,  60,   1,  1,   0};
    tbl[13] = '{0, 8'hD5,   60, 1, -1,   -1, 8,  0,    0,  0,   1};
    tbl[14] = '{5, 8'h55,    0, 0, -1,   -1, 8,  0,    0,  0,   1};
    tbl[15] = '{7, 8'hD5,    0, 0, -1,   -1, 8,  0,    1,  0,   0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst/out_valid", int'(rx_if.out_valid), 0);
    check("rst/out_sof",   int'(rx_if.out_sof),   0);
    check("rst/out_end",   int'(rx_if.out_end),   0);
    check("rst/out_good",  int'(rx_if.out_good),  0);
    check("rst/out_data",  int'(rx_if.out_data),  0);
    check("rst/cnt_ok",    int'(cnt_ok),   0);
    check("rst/cnt_bad",   int'(cnt_bad),  0);
    check("rst/cnt_drop",  int'(cnt_drop), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Vector table
    for (int r = 0; r < 16; r++) begin
      build(tbl[r].pre_n, tbl[r].sfd, tbl[r].data_n, tbl[r].add_fcs,
            tbl[r].flip_idx, tbl[r].er_idx, 1'b0, s, e, b0);
      send(s, e, b0, tbl[r].ifg);
      for (int k = 0; k < tbl[r].exp_beats; k++) begin
        exp_data.push_back(s[b0 + k]);
        exp_sof.push_back(k == 0);
      end
      if (tbl[r].exp_end) begin
        exp_good.push_back(tbl[r].exp_good);
        if (tbl[r].exp_good) exp_ok = sat(exp_ok);
        else                 exp_bad = sat(exp_bad);
      end
      if (tbl[r].exp_drop) exp_drop = sat(exp_drop);
      if (tbl[r].ifg > 1) flush($sformatf("vec%0d", r));
    end

    // Latency: first beat 6 register stages after its pin sample, end strobe 2 after dv low
    build(7, 8'hD5, 60, 1, -1, -1, 0, s, e, b0);
    send(s, e, b0, 8);
    model_frame(s, e);
    check("lat/first_beat", (obs_cyc.size() > 0) ? obs_cyc[0] - t_body : -1, 5);
    check("lat/out_end", (obs_end_cyc.size() > 0) ? obs_end_cyc[0] - t_low : -1, 1);
    flush("lat");

    // Reset in mid-frame, released while dv is still high
    build(7, 8'hD5, 60, 1, -1, -1, 0, s, e, b0);
    foreach (s[i]) begin
      @(negedge clk);
      dv = 1'b1; er = e[i]; data = s[i];
      if (i == b0 + 25) rst = 1'b0;
      if (i == b0 + 26) begin
        #1;
        check("midrst/out_valid", int'(rx_if.out_valid), 0);
        check("midrst/cnt_ok",    int'(cnt_ok),   0);
        check("midrst/cnt_bad",   int'(cnt_bad),  0);
        check("midrst/cnt_drop",  int'(cnt_drop), 0);
        clear_all();
        exp_ok = 0; exp_bad = 0; exp_drop = 0;
      end
      if (i == b0 + 28) rst = 1'b1;
    end
    @(negedge clk);
    dv = 1'b0; er = 1'b0; data = '0;
    repeat (6) @(negedge clk);
    exp_drop = 1;
    flush("midrst_tail");
    build(7, 8'hD5, 60, 1, -1, -1, 0, s, e, b0);
    send(s, e, b0, 8);
    model_frame(s, e);
    flush("after_rst");

    // Randomized frames against the model
    for (int r = 0; r < 50; r++) begin
      int pre_n  = $urandom_range(0, 8);
      logic [7:0] sfd = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hD5;
      int data_n = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 90) : $urandom_range(56, 64);
      bit fcs    = ($urandom_range(0, 7) != 0);
      int flip   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, data_n + 3) : -1;
      int eri    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, data_n + 3) : -1;
      int ifg    = $urandom_range(1, 4);
      build(pre_n, sfd, data_n, fcs, flip, eri, 1'b1, s, e, b0);
      send(s, e, b0, ifg);
      model_frame(s, e);
      if (ifg > 1) flush($sformatf("rnd%0d", r));
    end
    repeat (4) @(negedge clk);
    flush("rnd_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
